// File: rtl/du_loader_ctrl.sv
// Debug-unit controller: UART commands load instruction memory, run or single-step the
// pipeline and report the cycle count. Optional DU_LOAD_CHECKSUM_EN adds a post-load XOR byte.
module du_loader_ctrl #(
  parameter int unsigned        NB_DATA   = 32,
  parameter int unsigned        N_BITS    = 8,
  parameter int unsigned        ADDR_W    = 10,
  parameter logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}}
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [N_BITS-1:0]  rx_data_i,
  input  logic               rx_valid_i,
  input  logic               halt_i,
  input  logic               tx_busy_i,
  output logic [N_BITS-1:0]  tx_data_o,
  output logic               tx_start_o,
  output logic               en_write_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [NB_DATA-1:0] inst_load_o,
  output logic               debug_unit_o,
  output logic               enable_pipe_o,
  output logic               ack_debug_o,
  output logic               end_send_data_o,
  output logic [3:0]         state_o
);

  localparam int unsigned Bpw  = NB_DATA / N_BITS;
  localparam int unsigned CntW = $clog2(Bpw + 1);
  localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;

  localparam logic [N_BITS-1:0] CmdLoad = N_BITS'(8'h4C);
  localparam logic [N_BITS-1:0] CmdRun  = N_BITS'(8'h43);
  localparam logic [N_BITS-1:0] CmdStep = N_BITS'(8'h53);
  localparam logic [N_BITS-1:0] CmdNext = N_BITS'(8'h4E);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StLoad   = 4'd1,
    StWrite  = 4'd2,
    StRun    = 4'd3,
    StStep   = 4'd4,
    StReport = 4'd5,
    StTxWait = 4'd6,
    StCksum  = 4'd7
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CntW-1:0]    byte_cnt_q;
  logic [NB_DATA-1:0] word_q;
  logic [NB_DATA-1:0] cycle_q;
  logic [IdxW-1:0]    tx_idx_q;
  logic               skip_q;
  logic               pipe_en_q;
  logic               ack_q;
  logic               end_q;
  logic               en_write_q;
`ifdef DU_LOAD_CHECKSUM_EN
  logic [N_BITS-1:0]  cksum_q;
  logic               cks_sent_q;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      cycle_q    <= '0;
      tx_idx_q   <= '0;
      skip_q     <= 1'b0;
      pipe_en_q  <= 1'b0;
      ack_q      <= 1'b0;
      end_q      <= 1'b0;
      en_write_q <= 1'b0;
`ifdef DU_LOAD_CHECKSUM_EN
      cksum_q    <= '0;
      cks_sent_q <= 1'b0;
`endif
    end else begin
      en_write_q <= 1'b0;
      ack_q      <= 1'b0;
      end_q      <= 1'b0;
      pipe_en_q  <= 1'b0;
      if (enable_pipe_o) cycle_q <= cycle_q + NB_DATA'(1);
`ifdef DU_LOAD_CHECKSUM_EN
      if (rx_valid_i && (state_q == StLoad || state_q == StWrite)) begin
        cksum_q <= cksum_q ^ rx_data_i;
      end
`endif
      case (state_q)
        StIdle: begin
          if (rx_valid_i) begin
            if (rx_data_i == CmdLoad) begin
              state_q    <= StLoad;
              addr_q     <= '0;
              byte_cnt_q <= '0;
`ifdef DU_LOAD_CHECKSUM_EN
              cksum_q    <= '0;
`endif
            end else if (rx_data_i == CmdRun) begin
              state_q   <= StRun;
              cycle_q   <= '0;
              pipe_en_q <= 1'b1;
            end else if (rx_data_i == CmdStep) begin
              state_q <= StStep;
              cycle_q <= '0;
            end
          end
        end
        StLoad: begin
          if (rx_valid_i) begin
            word_q <= (word_q << N_BITS) | NB_DATA'(rx_data_i);
            if (byte_cnt_q == CntW'(Bpw - 1)) begin
              state_q    <= StWrite;
              en_write_q <= 1'b1;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + CntW'(1);
            end
          end
        end
        StWrite: begin
          if (word_q == HALT_WORD || addr_q == {ADDR_W{1'b1}}) begin
`ifdef DU_LOAD_CHECKSUM_EN
            state_q    <= StCksum;
            cks_sent_q <= 1'b0;
`else
            state_q <= StIdle;
`endif
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= StLoad;
            // A byte landing here is byte 0 of the next word.
            if (rx_valid_i) begin
              word_q <= (word_q << N_BITS) | NB_DATA'(rx_data_i);
              if (Bpw == 1) begin
                state_q    <= StWrite;
                en_write_q <= 1'b1;
              end else begin
                byte_cnt_q <= CntW'(1);
              end
            end
          end
        end
        StRun: begin
          if (halt_i) begin
            state_q  <= StReport;
            tx_idx_q <= '0;
          end else begin
            pipe_en_q <= 1'b1;
          end
        end
        StStep: begin
          if (halt_i) begin
            state_q  <= StReport;
            tx_idx_q <= '0;
          end else begin
            ack_q <= pipe_en_q;
            if (rx_valid_i && rx_data_i == CmdNext) begin
              pipe_en_q <= 1'b1;
            end else if (rx_valid_i && rx_data_i == CmdRun) begin
              pipe_en_q <= 1'b1;
              state_q   <= StRun;
            end
          end
        end
        StReport: begin
          if (!tx_busy_i) begin
            state_q <= StTxWait;
            skip_q  <= 1'b1;
          end
        end
        StTxWait: begin
          // Busy from the transmitter only shows up one cycle after the start strobe.
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!tx_busy_i) begin
            if (tx_idx_q == IdxW'(Bpw - 1)) begin
              end_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              tx_idx_q <= tx_idx_q + IdxW'(1);
              state_q  <= StReport;
            end
          end
        end
`ifdef DU_LOAD_CHECKSUM_EN
        StCksum: begin
          if (!cks_sent_q) begin
            if (!tx_busy_i) begin
              cks_sent_q <= 1'b1;
              skip_q     <= 1'b1;
            end
          end else if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!tx_busy_i) begin
            state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    debug_unit_o  = (state_q == StIdle) || (state_q == StLoad) || (state_q == StWrite) ||
                    (state_q == StCksum);
    enable_pipe_o = pipe_en_q & ~halt_i;
    tx_start_o    = ~tx_busy_i & (state_q == StReport);
    tx_data_o     = N_BITS'(cycle_q >> (N_BITS * tx_idx_q));
`ifdef DU_LOAD_CHECKSUM_EN
    if (state_q == StCksum) begin
      tx_start_o = ~tx_busy_i & ~cks_sent_q;
      tx_data_o  = cksum_q;
    end
`endif
  end

  assign en_write_o      = en_write_q;
  assign address_o       = addr_q;
  assign inst_load_o     = word_q;
  assign ack_debug_o     = ack_q;
  assign end_send_data_o = end_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_du_loader_ctrl.sv
// Randomized bench for du_loader_ctrl: a 32-bit/10-bit instance and a 16-bit/2-bit instance,
// checked against a word-assembly model, a UART busy model and cycle-count expectations.
module tb_du_loader_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_rx = '0;
  logic        a_rxv = 1'b0, a_halt = 1'b0, a_busy = 1'b0;
  logic [7:0]  a_txd;
  logic        a_txs, a_wr, a_dbg, a_en, a_ack, a_end;
  logic [9:0]  a_addr;
  logic [31:0] a_inst;
  logic [3:0]  a_state;

  logic [7:0]  b_rx = '0;
  logic        b_rxv = 1'b0, b_halt = 1'b0, b_busy = 1'b0;
  logic [7:0]  b_txd;
  logic        b_txs, b_wr, b_dbg, b_en, b_ack, b_end;
  logic [1:0]  b_addr;
  logic [15:0] b_inst;
  logic [3:0]  b_state;

  du_loader_ctrl u_dut_a (
    .clock_i(clk), .reset_i(rst_n), .rx_data_i(a_rx), .rx_valid_i(a_rxv), .halt_i(a_halt),
    .tx_busy_i(a_busy), .tx_data_o(a_txd), .tx_start_o(a_txs), .en_write_o(a_wr),
    .address_o(a_addr), .inst_load_o(a_inst), .debug_unit_o(a_dbg), .enable_pipe_o(a_en),
    .ack_debug_o(a_ack), .end_send_data_o(a_end), .state_o(a_state)
  );

  du_loader_ctrl #(.NB_DATA(16), .N_BITS(8), .ADDR_W(2), .HALT_WORD(16'hFFFF)) u_dut_b (
    .clock_i(clk), .reset_i(rst_n), .rx_data_i(b_rx), .rx_valid_i(b_rxv), .halt_i(b_halt),
    .tx_busy_i(b_busy), .tx_data_o(b_txd), .tx_start_o(b_txs), .en_write_o(b_wr),
    .address_o(b_addr), .inst_load_o(b_inst), .debug_unit_o(b_dbg), .enable_pipe_o(b_en),
    .ack_debug_o(b_ack), .end_send_data_o(b_end), .state_o(b_state)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] a_wr_q[$], b_wr_q[$], exp_q[$];
  logic [7:0]  a_tx_q[$], b_tx_q[$], bytes[$];
  logic [7:0]  exp_cks;
  int a_en_cnt = 0, a_ack_cnt = 0, a_end_cnt = 0, a_viol = 0;
  int b_en_cnt = 0, b_end_cnt = 0, b_viol = 0;
  int a_busy_left = 0, b_busy_left = 0;

  // Observers: {address, data} per write strobe, transmitted bytes, pulse counts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_wr) a_wr_q.push_back({32'(a_addr), a_inst});
      if (a_en) a_en_cnt++;
      if (a_ack) a_ack_cnt++;
      if (a_end) a_end_cnt++;
      if (a_txs) begin
        if (a_busy) a_viol++;
        a_tx_q.push_back(a_txd);
      end
      if (b_wr) b_wr_q.push_back({32'(b_addr), 16'h0, b_inst});
      if (b_en) b_en_cnt++;
      if (b_end) b_end_cnt++;
      if (b_txs) begin
        if (b_busy) b_viol++;
        b_tx_q.push_back(b_txd);
      end
    end
  end

  // UART transmitter models: busy for a random number of cycles after each start strobe.
  always @(posedge clk) begin
    if (!rst_n) begin
      a_busy <= 1'b0; a_busy_left <= 0;
    end else if (a_txs) begin
      a_busy <= 1'b1; a_busy_left <= int'($urandom_range(2, 6));
    end else if (a_busy_left > 1) begin
      a_busy_left <= a_busy_left - 1;
    end else begin
      a_busy <= 1'b0; a_busy_left <= 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      b_busy <= 1'b0; b_busy_left <= 0;
    end else if (b_txs) begin
      b_busy <= 1'b1; b_busy_left <= int'($urandom_range(2, 6));
    end else if (b_busy_left > 1) begin
      b_busy_left <= b_busy_left - 1;
    end else begin
      b_busy <= 1'b0; b_busy_left <= 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_obs();
    a_wr_q.delete(); a_tx_q.delete(); b_wr_q.delete(); b_tx_q.delete();
    a_en_cnt = 0; a_ack_cnt = 0; a_end_cnt = 0; a_viol = 0;
    b_en_cnt = 0; b_end_cnt = 0; b_viol = 0;
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    if (sel) begin b_rx = b; b_rxv = 1'b1; end
    else begin a_rx = b; a_rxv = 1'b1; end
    @(posedge clk); #1;
    a_rxv = 1'b0; b_rxv = 1'b0;
  endtask

  task automatic burst(input logic [7:0] data[$]);
    @(posedge clk); #1;
    foreach (data[i]) begin
      a_rx = data[i]; a_rxv = 1'b1;
      @(posedge clk); #1;
    end
    a_rxv = 1'b0;
  endtask

  task automatic halt_after(input bit sel, input int n);
    repeat (n) @(posedge clk);
    #1;
    if (sel) b_halt = 1'b1; else a_halt = 1'b1;
    @(posedge clk); #1;
    a_halt = 1'b0; b_halt = 1'b0;
  endtask

  task automatic wait_end(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((sel ? b_end_cnt : a_end_cnt) > 0) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [7:0] rand_data_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 254));
    while (b == 8'h4C || b == 8'h43 || b == 8'h53 || b == 8'h4E);
    return b;
  endfunction

  // Reference: chunk the byte stream into words MSB-first; stop at halt word or top address.
  function automatic void model_load(input logic [7:0] data[$], input int bpw, input int aw,
                                     input logic [31:0] halt);
    int addr = 0;
    logic [31:0] w;
    exp_q.delete();
    exp_cks = '0;
    for (int i = 0; i + bpw <= data.size(); i += bpw) begin
      w = '0;
      for (int j = 0; j < bpw; j++) begin
        w = (w << 8) | 32'(data[i + j]);
        exp_cks = exp_cks ^ data[i + j];
      end
      exp_q.push_back({32'(addr), w});
      if (w == halt || addr == (1 << aw) - 1) break;
      addr++;
    end
  endfunction

  task automatic test_reset();
    a_rxv = 0; a_halt = 0; b_rxv = 0; b_halt = 0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_state, a_dbg, a_wr, a_en, a_ack, a_end, a_txs} !== {4'd0, 6'b100000}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required %b", {a_state, a_dbg, a_wr, a_en, a_ack,
               a_end, a_txs}, {4'd0, 6'b100000});
    end
    vectors++;
    if ({a_txd, a_addr, a_inst} !== 50'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {a_txd, a_addr, a_inst});
    end
    vectors++;
    if ({b_state, b_dbg, b_en, b_txs} !== {4'd0, 3'b100}) begin
      miscompares++;
      $display("FAIL reset_b: got %b required %b", {b_state, b_dbg, b_en, b_txs}, 7'b0000100);
    end
    // Async reset mid-load after two bytes.
    clear_obs();
    send(0, 8'h4C); send(0, 8'h12); send(0, 8'h34);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_state, a_dbg, a_wr} !== {4'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL reset_midload: got %b required %b", {a_state, a_dbg, a_wr}, 6'b000010);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 8'h4C); send(0, 8'h20); send(0, 8'h01); send(0, 8'h00); send(0, 8'h05);
    @(negedge clk);
    vectors++;
    if ({a_wr, a_addr, a_inst} !== {1'b1, 10'd0, 32'h2001_0005}) begin
      miscompares++;
      $display("FAIL first_write: got %h required %h", {a_wr, a_addr, a_inst},
               {1'b1, 10'd0, 32'h2001_0005});
    end
    @(negedge clk);
    vectors++;
    if ({a_wr, a_state} !== {1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL after_write: got %b required %b", {a_wr, a_state}, 5'b00001);
    end
    repeat (4) send(0, 8'hFF);
    repeat (3) @(negedge clk);
    vectors++;
    if (a_wr_q.size() != 2 || a_state !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_reload: got %0d writes state %0d required 2 writes state 0",
               a_wr_q.size(), a_state);
    end else begin
      vectors++;
      if (a_wr_q[1] !== {32'd1, 32'hFFFF_FFFF}) begin
        miscompares++;
        $display("FAIL halt_write: got %h required %h", a_wr_q[1], {32'd1, 32'hFFFF_FFFF});
      end
    end
    repeat (40) @(posedge clk);
  endtask

  task automatic check_load(input string name);
    vectors++;
    if (a_wr_q.size() != exp_q.size() || a_state !== 4'd0 || a_dbg !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_count: got %0d writes state %0d required %0d writes state 0",
               name, a_wr_q.size(), a_state, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (a_wr_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL %s_word%0d: got %h required %h", name, i, a_wr_q[i], exp_q[i]);
        end
      end
    end
    repeat (40) @(posedge clk);
    vectors++;
`ifdef DU_LOAD_CHECKSUM_EN
    if (a_tx_q.size() != 1 || a_tx_q[0] !== exp_cks) begin
      miscompares++;
      $display("FAIL %s_cksum: got %0d bytes first %h required 1 byte %h", name,
               a_tx_q.size(), (a_tx_q.size() > 0) ? a_tx_q[0] : 8'h00, exp_cks);
    end
`else
    if (a_tx_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_notx: got %0d tx bytes required 0", name, a_tx_q.size());
    end
`endif
  endtask

  task automatic build_words(input int nw);
    bytes.delete();
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++) bytes.push_back(8'($urandom_range(0, 255)));
      if (bytes[bytes.size() - 1] == 8'hFF && bytes[bytes.size() - 2] == 8'hFF &&
          bytes[bytes.size() - 3] == 8'hFF && bytes[bytes.size() - 4] == 8'hFF)
        bytes[bytes.size() - 4] = 8'h00;
    end
    repeat (4) bytes.push_back(8'hFF);
  endtask

  task automatic test_load_random();
    for (int rep = 0; rep < 3; rep++) begin
      clear_obs();
      build_words(int'($urandom_range(1, 6)));
      send(0, 8'h4C);
      foreach (bytes[i]) send(0, bytes[i]);
      repeat (3) @(negedge clk);
      model_load(bytes, 4, 10, 32'hFFFF_FFFF);
      check_load("load");
    end
  endtask

  task automatic test_back_to_back();
    for (int rep = 0; rep < 2; rep++) begin
      clear_obs();
      build_words(int'($urandom_range(2, 5)));
      send(0, 8'h4C);
      burst(bytes);
      repeat (3) @(negedge clk);
      model_load(bytes, 4, 10, 32'hFFFF_FFFF);
      check_load("b2b");
    end
  endtask

  task automatic check_report(input bit sel, input string name, input int count, input int nb);
    bit ok;
    logic [7:0] exp_b;
    wait_end(sel, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: got no end_send_data pulse required one", name);
    end
    vectors++;
    if ((sel ? b_tx_q.size() : a_tx_q.size()) != nb) begin
      miscompares++;
      $display("FAIL %s_nbytes: got %0d required %0d", name,
               sel ? b_tx_q.size() : a_tx_q.size(), nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        exp_b = 8'(count >> (8 * i));
        vectors++;
        if ((sel ? b_tx_q[i] : a_tx_q[i]) !== exp_b) begin
          miscompares++;
          $display("FAIL %s_byte%0d: got %h required %h", name, i,
                   sel ? b_tx_q[i] : a_tx_q[i], exp_b);
        end
      end
    end
    vectors++;
    if ((sel ? b_viol : a_viol) != 0 || (sel ? b_state : a_state) !== 4'd0) begin
      miscompares++;
      $display("FAIL %s_handshake: got %0d starts while busy, state %0d required 0, 0", name,
               sel ? b_viol : a_viol, sel ? b_state : a_state);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_run(input int n);
    clear_obs();
    send(0, 8'h43);
    halt_after(0, n);
    vectors++;
    if (a_en_cnt != n) begin
      miscompares++;
      $display("FAIL run_enable: got %0d enabled cycles required %0d", a_en_cnt, n);
    end
    check_report(0, "run", n, 4);
    vectors++;
    if (a_end_cnt != 1) begin
      miscompares++;
      $display("FAIL run_endpulse: got %0d pulses required 1", a_end_cnt);
    end
  endtask

  task automatic test_step();
    int m;
    clear_obs();
    send(0, 8'h53);
    repeat (3) @(negedge clk);
    vectors++;
    if (a_en !== 1'b0 || a_state !== 4'd4) begin
      miscompares++;
      $display("FAIL step_idle: got en %b state %0d required 0, 4", a_en, a_state);
    end
    for (int k = 0; k < 3; k++) begin
      send(0, 8'h4E);
      @(negedge clk);
      vectors++;
      if ({a_en, a_ack} !== 2'b10) begin
        miscompares++;
        $display("FAIL step_pulse%0d: got en,ack %b required 10", k, {a_en, a_ack});
      end
      @(negedge clk);
      vectors++;
      if ({a_en, a_ack} !== 2'b01) begin
        miscompares++;
        $display("FAIL step_ack%0d: got en,ack %b required 01", k, {a_en, a_ack});
      end
      @(negedge clk);
      vectors++;
      if ({a_en, a_ack} !== 2'b00) begin
        miscompares++;
        $display("FAIL step_quiet%0d: got en,ack %b required 00", k, {a_en, a_ack});
      end
    end
    m = int'($urandom_range(5, 20));
    send(0, 8'h43);
    @(negedge clk);
    vectors++;
    if (a_en !== 1'b1 || a_state !== 4'd3) begin
      miscompares++;
      $display("FAIL step_resume: got en %b state %0d required 1, 3", a_en, a_state);
    end
    halt_after(0, m);
    vectors++;
    if (a_en_cnt != 3 + m || a_ack_cnt != 3) begin
      miscompares++;
      $display("FAIL step_counts: got %0d enables %0d acks required %0d, 3", a_en_cnt,
               a_ack_cnt, 3 + m);
    end
    check_report(0, "step", 3 + m, 4);
  endtask

  task automatic test_step_halt();
    clear_obs();
    send(0, 8'h53);
    send(0, 8'h4E);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    a_rx = 8'h4E; a_rxv = 1'b1; a_halt = 1'b1;
    @(posedge clk); #1;
    a_rxv = 1'b0; a_halt = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_en !== 1'b0 || a_state !== 4'd5 || a_en_cnt != 1) begin
      miscompares++;
      $display("FAIL step_halt: got en %b state %0d enables %0d required 0, 5, 1", a_en,
               a_state, a_en_cnt);
    end
    check_report(0, "stephalt", 1, 4);
  endtask

  task automatic test_reset_mid_run();
    clear_obs();
    send(0, 8'h43);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (a_state !== 4'd0 || a_en !== 1'b0 || a_dbg !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_run: got state %0d en %b dbg %b required 0, 0, 1", a_state, a_en,
               a_dbg);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_obs();
    repeat (40) @(posedge clk);
    vectors++;
    if (a_tx_q.size() != 0 || a_end_cnt != 0 || a_en_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_run_quiet: got %0d tx %0d end %0d en required 0, 0, 0",
               a_tx_q.size(), a_end_cnt, a_en_cnt);
    end
    send(0, 8'h43);
    halt_after(0, 5);
    check_report(0, "rerun", 5, 4);
  endtask

  task automatic test_addr_wrap();
    clear_obs();
    bytes.delete();
    for (int i = 0; i < 10; i++) bytes.push_back(rand_data_byte());
    send(1, 8'h4C);
    foreach (bytes[i]) send(1, bytes[i]);
    repeat (3) @(negedge clk);
    model_load(bytes, 2, 2, 32'h0000_FFFF);
    vectors++;
    if (b_wr_q.size() != exp_q.size() || exp_q.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d writes required %0d (4)", b_wr_q.size(),
               exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (b_wr_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL wrap_word%0d: got %h required %h", i, b_wr_q[i], exp_q[i]);
        end
      end
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (b_state !== 4'd0 || b_wr_q.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_idle: got state %0d writes %0d required 0, 4", b_state,
               b_wr_q.size());
    end
  endtask

  task automatic test_small_width();
    clear_obs();
    send(1, 8'h4C); send(1, 8'hAB); send(1, 8'hCD); send(1, 8'hFF); send(1, 8'hFF);
    repeat (3) @(negedge clk);
    vectors++;
    if (b_wr_q.size() != 2) begin
      miscompares++;
      $display("FAIL w16_count: got %0d writes required 2", b_wr_q.size());
    end else begin
      vectors++;
      if (b_wr_q[0] !== {32'd0, 32'h0000_ABCD} || b_wr_q[1] !== {32'd1, 32'h0000_FFFF}) begin
        miscompares++;
        $display("FAIL w16_words: got %h %h required %h %h", b_wr_q[0], b_wr_q[1],
                 {32'd0, 32'h0000_ABCD}, {32'd1, 32'h0000_FFFF});
      end
    end
    repeat (40) @(posedge clk);
    clear_obs();
    send(1, 8'h43);
    halt_after(1, 300);
    check_report(1, "w16run", 300, 2);
  endtask

  initial begin
    test_reset();
    test_load_random();
    test_back_to_back();
    test_run(37);
    test_run(int'($urandom_range(1, 90)));
    test_step();
    test_step_halt();
    test_reset_mid_run();
    test_addr_wrap();
    test_small_width();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
